xt_lbus_arbiter: RTL

//  Shares one XT local-bus master port (XT_LBUS_Pkg::lb_slave_t) between NUM_MASTERS requesters (CPU, debug, DMA).
//  - Round-robin arbitration, one transfer at a time.
//  - Fixed 3-cycle sequence per transfer: arbitrate, strobe, respond.
//  - Sits between the requesters and the LBUS address decoder/slaves.

---
 rtl/xt_lbus_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/xt_lbus_arbiter.sv
// Round-robin arbiter sharing one XT local-bus master port among NUM_MASTERS requesters.
// Optional grant locking is compiled in with `define XT_LBUS_LOCK_EN.

package XT_LBUS_Pkg;
  localparam int LB_ADDR_WIDTH = 8;

  typedef struct packed {
    logic                     ren;
    logic                     wen;
    logic [LB_ADDR_WIDTH-1:0] addr;
    logic [1:0]               write_width;
    logic [31:0]              wdata;
  } lb_slave_t;
endpackage

module xt_lbus_arbiter
  import XT_LBUS_Pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int MIDX_W      = $clog2(NUM_MASTERS)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_MASTERS-1:0]               m_req,
  input  logic [NUM_MASTERS-1:0]               m_wen,
  input  logic [NUM_MASTERS*LB_ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*2-1:0]             m_wwidth,
  input  logic [NUM_MASTERS*32-1:0]            m_wdata,
  input  logic [NUM_MASTERS-1:0]               m_lock,
  output logic [NUM_MASTERS-1:0]               m_ack,
  output logic [31:0]                          m_rdata,
  output lb_slave_t                            xt_lb,
  input  logic [31:0]                          lb_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [MIDX_W-1:0]   rr_q, rr_d;       // last winner; doubles as current grant index
  lb_slave_t           bus_q, bus_d;
  logic                wr_q, wr_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                lock_q, lock_d;
  logic [NUM_MASTERS-1:0] eligible;
  logic [MIDX_W-1:0]   win;
  logic                found;

`ifndef XT_LBUS_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^m_lock;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= MIDX_W'(NUM_MASTERS - 1);
      bus_q   <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      bus_q   <= bus_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    eligible = m_req;
    lock_d   = lock_q;
`ifdef XT_LBUS_LOCK_EN
    // A held lock narrows the candidate set to the owner; releasing falls back to normal RR.
    if (state_q == S_IDLE && lock_q) begin
      if (m_req[rr_q] && m_lock[rr_q]) begin
        eligible       = '0;
        eligible[rr_q] = 1'b1;
      end else begin
        lock_d = 1'b0;
      end
    end
    if (state_q == S_RESP) lock_d = m_lock[rr_q];
`else
    lock_d = 1'b0;
`endif
    found = 1'b0;
    win   = rr_q;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      int unsigned idx;
      idx = (32'(rr_q) + i) % unsigned'(NUM_MASTERS);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = MIDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    bus_d     = bus_q;
    bus_d.ren = 1'b0;
    bus_d.wen = 1'b0;
    wr_d      = wr_q;
    rdata_d   = rdata_q;
    m_ack     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          rr_d              = win;
          wr_d              = m_wen[win];
          bus_d.ren         = !m_wen[win];
          bus_d.wen         = m_wen[win];
          bus_d.addr        = m_addr[win*LB_ADDR_WIDTH +: LB_ADDR_WIDTH];
          bus_d.write_width = m_wwidth[win*2 +: 2];
          bus_d.wdata       = m_wdata[win*32 +: 32];
          state_d           = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_RESP;
      S_RESP: begin
        m_ack[rr_q] = 1'b1;
        if (!wr_q) rdata_d = lb_rdata;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read data is forwarded combinationally in the ack cycle, then held from the register.
  assign m_rdata = (state_q == S_RESP && !wr_q) ? lb_rdata : rdata_q;
  assign xt_lb   = bus_q;

endmodule
